// File: rtl/led_pattern_sequencer_if.sv
// Button inputs and display outputs of the LED pattern sequencer.
// The board/bench drives through master; the sequencer attaches through slave.
interface led_pattern_sequencer_if #(
  parameter int unsigned Bits = 5
) ();
  logic            btn_n;
  logic            btn1;
  logic            btn2;
  logic            btn3;
  logic [Bits-1:0] leds;
  logic            running;
  logic [1:0]      mode;
  logic [2:0]      rate;

  modport master (
    output btn_n, btn1, btn2, btn3,
    input  leds, running, mode, rate
  );

  modport slave (
    input  btn_n, btn1, btn2, btn3,
    output leds, running, mode, rate
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Button-driven LED pattern counter: debounced run/pause, step rate and display mode
// controls sequencing a Bits-wide counter shown as binary, gray, down or bounce.
module led_pattern_sequencer #(
  parameter int unsigned Bits          = 5,
  parameter int unsigned DebounceLog2  = 16,
  parameter int unsigned BaseLog2Delay = 22
) (
  input logic                    clk_i,
  input logic                    rst_i,
  led_pattern_sequencer_if.slave bus_io
);

  localparam logic [DebounceLog2-1:0]  DbOne  = {{(DebounceLog2-1){1'b0}}, 1'b1};
  localparam logic [BaseLog2Delay-1:0] PreOne = {{(BaseLog2Delay-1){1'b0}}, 1'b1};
  localparam logic [Bits-1:0]          CntOne = {{(Bits-1){1'b0}}, 1'b1};
  localparam logic [Bits-1:0]          CntMax = '1;

  typedef enum logic {StPause, StRun} state_e;

  // Bit order: 0 run/pause (inverted to pressed-high), 1 faster, 2 slower, 3 mode.
  logic [3:0]              btn_raw;
  logic [3:0]              sync1_q, sync2_q;
  logic [3:0]              db_lvl_q, lvl_prev_q;
  logic [DebounceLog2-1:0] db_cnt_q [4];
  logic [3:0]              ev;

  state_e                   state_q, state_d;
  logic [2:0]               rate_q, rate_d;
  logic [1:0]               mode_q, mode_d;
  logic                     dir_down_q, dir_down_d;
  logic [Bits-1:0]          cnt_q, cnt_d;
  logic [BaseLog2Delay-1:0] pre_q, pre_d;
  logic [BaseLog2Delay-1:0] pre_limit;
  logic                     tick;

  assign btn_raw = {bus_io.btn3, bus_io.btn2, bus_io.btn1, ~bus_io.btn_n};
  assign ev      = db_lvl_q & ~lvl_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_lvl_q   <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= db_lvl_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (&db_cnt_q[i]) begin
          db_cnt_q[i] <= '0;
          db_lvl_q[i] <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbOne;
        end
      end
    end
  end

  // All-ones when the shift reaches the full width, giving the 2^BaseLog2Delay period.
  assign pre_limit = (PreOne << (BaseLog2Delay - 32'(rate_q))) - PreOne;

  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    mode_d     = mode_q;
    dir_down_d = dir_down_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    tick       = 1'b0;

    if (ev[0]) state_d = (state_q == StRun) ? StPause : StRun;

    if (ev[1] && !ev[2] && rate_q != 3'd7) begin
      rate_d = rate_q + 3'd1;
    end else if (ev[2] && !ev[1] && rate_q != 3'd0) begin
      rate_d = rate_q - 3'd1;
    end

    if (ev[3]) begin
      mode_d     = mode_q + 2'd1;
      dir_down_d = 1'b0;
    end

    if (state_q == StRun) begin
      if (pre_q == pre_limit) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PreOne;
      end
    end
    if (rate_d != rate_q) pre_d = '0;

    // A step coinciding with a mode change follows the new mode and reset direction.
    if (tick) begin
      unique case (mode_d)
        2'd0, 2'd1: cnt_d = cnt_q + CntOne;
        2'd2:       cnt_d = cnt_q - CntOne;
        2'd3: begin
          if (!dir_down_d) begin
            if (cnt_q == CntMax) begin
              cnt_d      = cnt_q - CntOne;
              dir_down_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            if (cnt_q == '0) begin
              cnt_d      = cnt_q + CntOne;
              dir_down_d = 1'b0;
            end else begin
              cnt_d = cnt_q - CntOne;
            end
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StPause;
      rate_q     <= '0;
      mode_q     <= '0;
      dir_down_q <= 1'b0;
      cnt_q      <= '0;
      pre_q      <= '0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      mode_q     <= mode_d;
      dir_down_q <= dir_down_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
    end
  end

  assign bus_io.leds    = (mode_q == 2'd1) ? (cnt_q ^ (cnt_q >> 1)) : cnt_q;
  assign bus_io.running = (state_q == StRun);
  assign bus_io.mode    = mode_q;
  assign bus_io.rate    = rate_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected LED values are queued as stimulus
// is applied and popped by a monitor whenever the displayed pattern changes.
module tb_led_pattern_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [4:0] sb [$];
  logic [4:0] prev_leds = '0;
  logic [4:0] exp_v;
  logic       mon_en = 1'b0;

  led_pattern_sequencer_if #(.Bits(5)) bus ();

  led_pattern_sequencer #(
    .Bits          (5),
    .DebounceLog2  (2),
    .BaseLog2Delay (8)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && bus.leds != prev_leds) begin
      if (sb.size() == 0) begin
        check("unexpected_led_change", 32'(bus.leds), 32'(prev_leds));
      end else begin
        exp_v = sb.pop_front();
        check("led_step", 32'(bus.leds), 32'(exp_v));
      end
    end
    prev_leds = bus.leds;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int idx, input logic pressed);
    case (idx)
      0:       bus.btn_n = ~pressed;
      1:       bus.btn1  = pressed;
      2:       bus.btn2  = pressed;
      default: bus.btn3  = pressed;
    endcase
  endtask

  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    cycles(10);
    set_btn(idx, 1'b0);
    cycles(10);
  endtask

  task automatic push_val(input int v);
    sb.push_back(5'(v));
  endtask

  task automatic wait_empty(input int max_cycles, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      cycles(1);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic reset_and_check(input string tag);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check({tag, "_leds"}, 32'(bus.leds), 32'd0);
    check({tag, "_running"}, 32'(bus.running), 32'd0);
    check({tag, "_mode"}, 32'(bus.mode), 32'd0);
    check({tag, "_rate"}, 32'(bus.rate), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(2);
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] l;
    bus.btn_n = 1'b1;
    bus.btn1  = 1'b0;
    bus.btn2  = 1'b0;
    bus.btn3  = 1'b0;
    cycles(3);
    reset_and_check("reset");

    // 1: run at rate 0, full 32-step binary wrap
    for (int v = 1; v < 32; v++) push_val(v);
    push_val(0);
    press(0);
    check("t1_running", 32'(bus.running), 32'd1);
    wait_empty(32 * 256 + 300, "t1_wrap");
    press(0);
    check("t1_paused", 32'(bus.running), 32'd0);

    // 2: short glitches must not register
    for (int k = 0; k < 5; k++) begin
      bus.btn1 = 1'b1;
      cycles(3);
      bus.btn1 = 1'b0;
      cycles(3);
    end
    cycles(10);
    check("t2_glitch_rate", 32'(bus.rate), 32'd0);

    // 3: speed up to saturation, simultaneous press ignored, period 2
    press(1);
    check("t3_rate1", 32'(bus.rate), 32'd1);
    for (int k = 0; k < 8; k++) press(1);
    check("t3_rate_sat", 32'(bus.rate), 32'd7);
    bus.btn1 = 1'b1;
    bus.btn2 = 1'b1;
    cycles(10);
    bus.btn1 = 1'b0;
    bus.btn2 = 1'b0;
    cycles(10);
    check("t3_rate_both", 32'(bus.rate), 32'd7);
    mon_en = 1'b0;
    press(0);
    for (int k = 0; k < 2; k++) begin
      l = bus.leds;
      n = 0;
      do begin
        cycles(1);
        n++;
      end while (bus.leds == l && n < 20);
      if (k == 1) check("t3_period", 32'(n), 32'd2);
    end
    reset_and_check("t3_reset");

    // 4: pause at 5, switch to gray, display holds
    for (int v = 1; v <= 5; v++) push_val(v);
    press(0);
    wait_empty(5 * 256 + 300, "t4_reach5");
    press(0);
    check("t4_paused", 32'(bus.running), 32'd0);
    push_val(7);
    press(3);
    check("t4_mode", 32'(bus.mode), 32'd1);
    check("t4_gray", 32'(bus.leds), 32'd7);
    cycles(1000);
    check("t4_hold", 32'(bus.leds), 32'd7);

    // 5: bounce through both endpoints, then binary-down wrap
    push_val(5);
    press(3);
    press(3);
    check("t5_mode3", 32'(bus.mode), 32'd3);
    for (int v = 6; v < 32; v++) push_val(v);
    for (int v = 30; v >= 0; v--) push_val(v);
    push_val(1);
    press(0);
    wait_empty(58 * 256 + 300, "t5_bounce");
    press(0);
    for (int k = 0; k < 3; k++) press(3);
    check("t5_mode2", 32'(bus.mode), 32'd2);
    push_val(0);
    push_val(31);
    press(0);
    wait_empty(2 * 256 + 300, "t5_down_wrap");
    press(0);
    check("t5_paused", 32'(bus.running), 32'd0);

    // 6: rate 3, reset mid-period, no step until run is pressed again
    press(2);
    check("t6_rate_floor", 32'(bus.rate), 32'd0);
    for (int k = 0; k < 3; k++) press(1);
    check("t6_rate3", 32'(bus.rate), 32'd3);
    push_val(30);
    press(0);
    wait_empty(200, "t6_step");
    cycles(10);
    reset_and_check("t6_reset");
    cycles(600);
    check("t6_quiet", 32'(bus.leds), 32'd0);
    push_val(1);
    press(0);
    wait_empty(400, "t6_restart");
    check("t6_running", 32'(bus.running), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
